javk_regfile: RTL and testbench

Parametrised general-purpose register file for the JAVK core. It replaces the flat register declarations in the CPU top with one instance. Features:
- Two combinational read ports and one synchronous write port.
- A hardwired zero register and a dedicated masked flags-update port.
- A 2*WIDTH register-pair read port with post-increment/decrement, used for address generation onto addrbus.

---
 rtl/javk_pkg.sv | 48 ++++
 rtl/javk_pair_incdec.sv | 25 ++
 rtl/javk_regfile.sv | 128 ++++++++++++
 tb/tb_javk_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/javk_pkg.sv
// Shared definitions for the JAVK core register file: default geometry,
// architectural register indices, flag bit positions and the pair-update
// opcode used by javk_pair_incdec.
package javk_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREG  = 16;

  // Architectural register indices. N is skipped so the register letters
  // never read like the negative flag.
  localparam int REG_A     = 0;
  localparam int REG_FLAGS = 1;
  localparam int REG_B     = 2;
  localparam int REG_C     = 3;
  localparam int REG_D     = 4;
  localparam int REG_E     = 5;
  localparam int REG_F     = 6;
  localparam int REG_G     = 7;
  localparam int REG_H     = 8;
  localparam int REG_I     = 9;
  localparam int REG_J     = 10;
  localparam int REG_K     = 11;
  localparam int REG_L     = 12;
  localparam int REG_M     = 13;
  localparam int REG_O     = 14;
  localparam int REG_ZR    = 15;

  // Bit positions inside the flags register.
  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 2;
  localparam int FLAG_OVERFLOW = 3;

  // Register-pair update selector.
  typedef enum logic [1:0] {
    PR_HOLD = 2'd0,
    PR_INC  = 2'd1,
    PR_DEC  = 2'd2
  } pr_op_e;

  // Collapse the raw inc/dec strobes; both asserted means hold.
  function automatic pr_op_e pr_op_decode(input logic inc, input logic dec);
    if (inc && !dec)      return PR_INC;
    else if (dec && !inc) return PR_DEC;
    else                  return PR_HOLD;
  endfunction

endpackage

// File: rtl/javk_pair_incdec.sv
// Combinational +1 / -1 / hold on a 2*WIDTH register pair. Arithmetic wraps
// modulo 2^(2*WIDTH); carry and borrow ripple across the byte boundary.
// Shared with the PC and stack-pointer logic.
module javk_pair_incdec
  import javk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] din,
  input  pr_op_e             op,
  output logic [2*WIDTH-1:0] dout
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Select the incremented, decremented or unchanged pair value.
  always_comb begin
    case (op)
      PR_INC:  dout = din + ONE;
      PR_DEC:  dout = din - ONE;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/javk_regfile.sv
// JAVK general-purpose register file: two combinational read ports, one
// synchronous write port, hardwired zero register, masked flags update and a
// post-increment/decrement register-pair port for address generation.
// Build option: JAVK_RF_BYPASS_EN enables write-through forwarding on reads.
module javk_regfile
  import javk_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NREG   = DEF_NREG,
  parameter  int ZR_IDX = NREG - 1,
  parameter  int FL_IDX = REG_FLAGS,
  localparam int AW     = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      ra_sel,
  output logic [WIDTH-1:0]   ra_data,
  input  logic [AW-1:0]      rb_sel,
  output logic [WIDTH-1:0]   rb_data,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               fl_we,
  input  logic [WIDTH-1:0]   fl_mask,
  input  logic [WIDTH-1:0]   fl_in,
  input  logic [AW-2:0]      pr_sel,
  input  logic               pr_inc,
  input  logic               pr_dec,
  output logic [2*WIDTH-1:0] pr_data,
  output logic [WIDTH-1:0]   flags
);

  logic [WIDTH-1:0]   regs     [NREG];
  logic [WIDTH-1:0]   regs_nxt [NREG];
  logic [WIDTH-1:0]   rval     [NREG];
  logic [AW-1:0]      pr_hi_idx;
  logic [AW-1:0]      pr_lo_idx;
  logic [2*WIDTH-1:0] pair_cur;
  logic [2*WIDTH-1:0] pair_nxt;
  logic [WIDTH-1:0]   pr_hi;
  logic [WIDTH-1:0]   pr_lo;
  pr_op_e             pr_op;

  assign pr_hi_idx = {pr_sel, 1'b0};
  assign pr_lo_idx = {pr_sel, 1'b1};
  assign pr_op     = pr_op_decode(pr_inc, pr_dec);

  // Architectural read view: the zero register always reads 0.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rval[i] = (i == ZR_IDX) ? '0 : regs[i];
    end
  end

  // Pair arithmetic works on pre-edge values, with the zero byte as 0.
  assign pair_cur = {rval[pr_hi_idx], rval[pr_lo_idx]};

  javk_pair_incdec #(
    .WIDTH (WIDTH)
  ) u_incdec (
    .din  (pair_cur),
    .op   (pr_op),
    .dout (pair_nxt)
  );

  // Next-state: later assignments override earlier ones, giving the
  // priority write port > pair update > flags update on any shared byte.
  always_comb begin
    // NOTE: every element gets a default first so no path leaves regs_nxt
    // unassigned, which would otherwise infer latches.
    for (int i = 0; i < NREG; i++) begin
      regs_nxt[i] = regs[i];
    end
    if (fl_we) begin
      regs_nxt[FL_IDX] = (regs[FL_IDX] & ~fl_mask) | (fl_in & fl_mask);
    end
    if (pr_op != PR_HOLD) begin
      regs_nxt[pr_hi_idx] = pair_nxt[2*WIDTH-1:WIDTH];
      regs_nxt[pr_lo_idx] = pair_nxt[WIDTH-1:0];
    end
    if (wr_en) begin
      regs_nxt[wr_sel] = wr_data;
    end
    regs_nxt[ZR_IDX] = '0;
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this file is built from flops rather than a RAM macro, so the
    // whole array is cleared on reset; a RAM-style array would not be.
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking here, blocking in the always_comb blocks; mixing
      // them up creates read-before-write races between flops.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

`ifdef JAVK_RF_BYPASS_EN
  localparam logic [AW-1:0] ZR_SEL = AW'(ZR_IDX);
  logic fwd_ok;
  // Forward only a real, non-zero-register write, and never during reset.
  assign fwd_ok = wr_en && !rst && (wr_sel != ZR_SEL);
`endif

  // Read ports, optionally forwarding the in-flight write.
  always_comb begin
    ra_data = rval[ra_sel];
    rb_data = rval[rb_sel];
    pr_hi   = rval[pr_hi_idx];
    pr_lo   = rval[pr_lo_idx];
`ifdef JAVK_RF_BYPASS_EN
    if (fwd_ok && (wr_sel == ra_sel))    ra_data = wr_data;
    if (fwd_ok && (wr_sel == rb_sel))    rb_data = wr_data;
    if (fwd_ok && (wr_sel == pr_hi_idx)) pr_hi   = wr_data;
    if (fwd_ok && (wr_sel == pr_lo_idx)) pr_lo   = wr_data;
`endif
  end

  assign pr_data = {pr_hi, pr_lo};
  assign flags   = rval[FL_IDX];

endmodule

// File: tb/tb_javk_regfile.sv
// Self-checking bench for javk_regfile (default geometry, WIDTH=8, NREG=16).
// Table of one-edge operations with hand-computed results, plus hand-written
// sequences for reset, same-cycle forwarding and back-to-back writes.
module tb_javk_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  ra_sel;
  logic [7:0]  ra_data;
  logic [3:0]  rb_sel;
  logic [7:0]  rb_data;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        fl_we;
  logic [7:0]  fl_mask;
  logic [7:0]  fl_in;
  logic [2:0]  pr_sel;
  logic        pr_inc;
  logic        pr_dec;
  logic [15:0] pr_data;
  logic [7:0]  flags;

  int total = 0;
  int bad   = 0;

  javk_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .ra_sel  (ra_sel),
    .ra_data (ra_data),
    .rb_sel  (rb_sel),
    .rb_data (rb_data),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .fl_we   (fl_we),
    .fl_mask (fl_mask),
    .fl_in   (fl_in),
    .pr_sel  (pr_sel),
    .pr_inc  (pr_inc),
    .pr_dec  (pr_dec),
    .pr_data (pr_data),
    .flags   (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        fl_we;
    logic [7:0]  fl_mask;
    logic [7:0]  fl_in;
    logic [2:0]  pr_sel;
    logic        pr_inc;
    logic        pr_dec;
    logic [3:0]  ra_sel;
    logic [3:0]  rb_sel;
    logic [7:0]  exp_ra;
    logic [7:0]  exp_rb;
    logic [15:0] exp_pr;
    logic [7:0]  exp_fl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    fl_we  = 1'b0;
    pr_inc = 1'b0;
    pr_dec = 1'b0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    ra_sel  = 4'd0;
    rb_sel  = 4'd0;
    wr_sel  = 4'd0;
    wr_data = 8'h00;
    fl_mask = 8'h00;
    fl_in   = 8'h00;
    pr_sel  = 3'd0;
    idle();

    // op: name, wr_en, wr_sel, wr_data, fl_we, fl_mask, fl_in, pr_sel, inc, dec
    // read: ra_sel, rb_sel; expect: ra, rb, pr, flags (after the edge)
    vecs.push_back('{"zr_write",    1'b1, 4'd15, 8'h3C, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 4'd15, 4'd15, 8'h00, 8'h00, 16'h0000, 8'h00});
    vecs.push_back('{"wr_r4",       1'b1, 4'd4,  8'h3C, 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 4'd4,  4'd15, 8'h3C, 8'h00, 16'h3C00, 8'h00});
    vecs.push_back('{"fl_full",     1'b1, 4'd1,  8'hF0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 4'd1,  4'd4,  8'hF0, 8'h3C, 16'h00F0, 8'hF0});
    vecs.push_back('{"fl_mask",     1'b0, 4'd0,  8'h00, 1'b1, 8'h0F, 8'h05, 3'd0, 1'b0, 1'b0, 4'd1,  4'd0,  8'hF5, 8'h00, 16'h00F5, 8'hF5});
    vecs.push_back('{"fl_vs_wr",    1'b1, 4'd1,  8'h11, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 4'd1,  4'd4,  8'h11, 8'h3C, 16'h0011, 8'h11});
    vecs.push_back('{"pr1_setup",   1'b1, 4'd3,  8'hFF, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 4'd3,  4'd2,  8'hFF, 8'h00, 16'h00FF, 8'h11});
    vecs.push_back('{"inc_carry",   1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 4'd2,  4'd3,  8'h01, 8'h00, 16'h0100, 8'h11});
    vecs.push_back('{"inc_dec",     1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b1, 4'd2,  4'd3,  8'h01, 8'h00, 16'h0100, 8'h11});
    vecs.push_back('{"dec_borrow",  1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, 4'd2,  4'd3,  8'h00, 8'hFF, 16'h00FF, 8'h11});
    vecs.push_back('{"clr_lo",      1'b1, 4'd3,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 4'd3,  4'd2,  8'h00, 8'h00, 16'h0000, 8'h11});
    vecs.push_back('{"dec_wrap",    1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, 4'd2,  4'd3,  8'hFF, 8'hFF, 16'hFFFF, 8'h11});
    vecs.push_back('{"inc_wrap",    1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 4'd2,  4'd3,  8'h00, 8'h00, 16'h0000, 8'h11});
    vecs.push_back('{"set_hi12",    1'b1, 4'd2,  8'h12, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 4'd2,  4'd3,  8'h12, 8'h00, 16'h1200, 8'h11});
    vecs.push_back('{"set_loFF",    1'b1, 4'd3,  8'hFF, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 4'd2,  4'd3,  8'h12, 8'hFF, 16'h12FF, 8'h11});
    vecs.push_back('{"inc_wr_lo",   1'b1, 4'd3,  8'h77, 1'b0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 4'd2,  4'd3,  8'h13, 8'h77, 16'h1377, 8'h11});
    vecs.push_back('{"set_r14",     1'b1, 4'd14, 8'h50, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 4'd14, 4'd15, 8'h50, 8'h00, 16'h5000, 8'h11});
    vecs.push_back('{"zr_pair_dec", 1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 4'd14, 4'd15, 8'h4F, 8'h00, 16'h4F00, 8'h11});
    vecs.push_back('{"zr_pair_inc", 1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0, 4'd14, 4'd15, 8'h4F, 8'h00, 16'h4F00, 8'h11});
    vecs.push_back('{"fl_pair_inc", 1'b0, 4'd0,  8'h00, 1'b1, 8'hFF, 8'hAA, 3'd0, 1'b1, 1'b0, 4'd1,  4'd0,  8'h12, 8'h00, 16'h0012, 8'h12});
    vecs.push_back('{"fl_wr_pair",  1'b1, 4'd1,  8'h80, 1'b1, 8'hFF, 8'h33, 3'd0, 1'b0, 1'b1, 4'd1,  4'd0,  8'h80, 8'h00, 16'h0080, 8'h80});
    vecs.push_back('{"fl_and_wr",   1'b1, 4'd6,  8'h5A, 1'b1, 8'h0F, 8'h0A, 3'd0, 1'b0, 1'b0, 4'd6,  4'd1,  8'h5A, 8'h8A, 16'h008A, 8'h8A});

    // Reset state: every output reads 0 while rst is held.
    #12;
    ra_sel = 4'd2;
    rb_sel = 4'd1;
    #1;
    check("rst_ra", {8'h00, ra_data}, 16'h0000);
    check("rst_rb", {8'h00, rb_data}, 16'h0000);
    check("rst_pr", pr_data, 16'h0000);
    check("rst_fl", {8'h00, flags}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation clears without any clock edge.
    tick();
    wr_en   = 1'b1;
    wr_sel  = 4'd2;
    wr_data = 8'hA5;
    tick();
    idle();
    pr_sel = 3'd1;
    #1;
    check("pre_rst_r2", {8'h00, ra_data}, 16'h00A5);
    rst = 1'b1;
    #1;
    check("async_rst_r2", {8'h00, ra_data}, 16'h0000);
    check("async_rst_pr", pr_data, 16'h0000);
    #1;
    rst = 1'b0;

    // Table-driven single-edge operations.
    foreach (vecs[k]) begin
      wr_en   = vecs[k].wr_en;
      wr_sel  = vecs[k].wr_sel;
      wr_data = vecs[k].wr_data;
      fl_we   = vecs[k].fl_we;
      fl_mask = vecs[k].fl_mask;
      fl_in   = vecs[k].fl_in;
      pr_sel  = vecs[k].pr_sel;
      pr_inc  = vecs[k].pr_inc;
      pr_dec  = vecs[k].pr_dec;
      tick();
      idle();
      ra_sel = vecs[k].ra_sel;
      rb_sel = vecs[k].rb_sel;
      #1;
      check({vecs[k].name, "_ra"}, {8'h00, ra_data}, {8'h00, vecs[k].exp_ra});
      check({vecs[k].name, "_rb"}, {8'h00, rb_data}, {8'h00, vecs[k].exp_rb});
      check({vecs[k].name, "_pr"}, pr_data, vecs[k].exp_pr);
      check({vecs[k].name, "_fl"}, {8'h00, flags}, {8'h00, vecs[k].exp_fl});
    end

    // Same-cycle visibility of a pending write (reg 9 is still 0 here).
    wr_en   = 1'b1;
    wr_sel  = 4'd9;
    wr_data = 8'hC3;
    ra_sel  = 4'd9;
    rb_sel  = 4'd15;
    pr_sel  = 3'd4;
    #1;
`ifdef JAVK_RF_BYPASS_EN
    check("fwd_ra_same", {8'h00, ra_data}, 16'h00C3);
    check("fwd_pr_same", pr_data, 16'h00C3);
`else
    check("fwd_ra_same", {8'h00, ra_data}, 16'h0000);
    check("fwd_pr_same", pr_data, 16'h0000);
`endif
    tick();
    idle();
    #1;
    check("fwd_ra_next", {8'h00, ra_data}, 16'h00C3);
    wr_en   = 1'b1;
    wr_sel  = 4'd15;
    wr_data = 8'h3C;
    #1;
    check("zr_no_fwd", {8'h00, rb_data}, 16'h0000);
    tick();
    idle();

    // Back-to-back writes on consecutive edges, one per register.
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_sel  = 4'(i);
      wr_data = 8'(i * 8'h11);
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      ra_sel = 4'(i);
      rb_sel = 4'(15 - i);
      #1;
      check($sformatf("b2b_ra%0d", i), {8'h00, ra_data},
            (i == 15) ? 16'h0000 : 16'(i * 8'h11));
      check($sformatf("b2b_rb%0d", 15 - i), {8'h00, rb_data},
            (i == 0) ? 16'h0000 : 16'((15 - i) * 8'h11));
    end
    pr_sel = 3'd3;
    #1;
    check("b2b_pr3", pr_data, 16'h6677);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
